// File: rtl/branch_resolve_unit.sv
// Execute-stage RV32I branch resolution, mispredict redirect and 2-bit BHT training/lookup.
// Optional statistics counters are enabled by defining BRU_STATS_EN.
module branch_resolve_unit #(
   parameter int unsigned BHT_ENTRIES = 64,
   parameter int unsigned PC_W        = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ex_valid_i,
   input  logic            ex_is_branch_i,
   input  logic [2:0]      ex_funct3_i,
   input  logic [PC_W-1:0] ex_pc_i,
   input  logic [PC_W-1:0] ex_imm_i,
   input  logic            ex_pred_taken_i,
   input  logic [PC_W-1:0] ex_pred_target_i,
   input  logic [31:0]     alu_f_i,
   input  logic            alu_zero_i,
   input  logic [PC_W-1:0] if_pc_i,
   output logic            if_pred_taken_o,
   output logic            redirect_o,
   output logic [PC_W-1:0] redirect_pc_o,
   output logic [31:0]     br_count_o,
   output logic [31:0]     mispred_count_o
);

   localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

   logic [BHT_ENTRIES-1:0][1:0] bht;
   logic [IDX_W-1:0]            if_idx;
   logic [IDX_W-1:0]            ex_idx;
   logic                        taken;
   logic                        legal;
   logic                        resolve;
   logic                        mispredict;
   logic [PC_W-1:0]             tgt;
   logic [PC_W-1:0]             fall_pc;
   logic [1:0]                  ctr_cur;
   logic [1:0]                  ctr_next;
   logic                        unused_bits;

   assign if_idx = if_pc_i[IDX_W+1:2];
   assign ex_idx = ex_pc_i[IDX_W+1:2];

   // The table is only written at the clock edge, so a same-index lookup
   // naturally returns the pre-update counter.
   assign if_pred_taken_o = bht[if_idx][1];

   always_comb begin
      taken = 1'b0;
      legal = 1'b1;
      unique case (ex_funct3_i)
         3'b000:         taken = alu_zero_i;
         3'b001:         taken = ~alu_zero_i;
         3'b100, 3'b110: taken = alu_f_i[0];
         3'b101, 3'b111: taken = ~alu_f_i[0];
         default:        legal = 1'b0;
      endcase
   end

   assign tgt     = ex_pc_i + ex_imm_i;
   assign fall_pc = ex_pc_i + PC_W'(4);

   // The EX instruction during a redirect cycle is wrong-path and is dropped.
   assign resolve = ex_valid_i & ex_is_branch_i & ~redirect_o & legal;

   assign mispredict = (taken != ex_pred_taken_i) |
                       (taken & ex_pred_taken_i & (ex_pred_target_i != tgt));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         redirect_o    <= 1'b0;
         redirect_pc_o <= '0;
      end else begin
         redirect_o <= resolve & mispredict;
         if (resolve && mispredict) begin
            redirect_pc_o <= taken ? tgt : fall_pc;
         end
      end
   end

   assign ctr_cur = bht[ex_idx];

   always_comb begin
      ctr_next = ctr_cur;
      if (taken) begin
         if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'b01;
      end else begin
         if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'b01;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bht <= {BHT_ENTRIES{2'b01}};
      end else if (resolve) begin
         bht[ex_idx] <= ctr_next;
      end
   end

`ifdef BRU_STATS_EN
   logic [31:0] br_count;
   logic [31:0] mispred_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_count      <= '0;
         mispred_count <= '0;
      end else if (resolve) begin
         if (br_count != '1) br_count <= br_count + 32'd1;
         if (mispredict && mispred_count != '1) mispred_count <= mispred_count + 32'd1;
      end
   end

   assign br_count_o      = br_count;
   assign mispred_count_o = mispred_count;
`else
   assign br_count_o      = '0;
   assign mispred_count_o = '0;
`endif

   assign unused_bits = ^{alu_f_i[31:1], if_pc_i[PC_W-1:IDX_W+2], if_pc_i[1:0],
                          ex_pc_i[PC_W-1:IDX_W+2], ex_pc_i[1:0]};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit (honours BRU_STATS_EN if defined).
module tb_branch_resolve_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid_i;
   logic        ex_is_branch_i;
   logic [2:0]  ex_funct3_i;
   logic [31:0] ex_pc_i;
   logic [31:0] ex_imm_i;
   logic        ex_pred_taken_i;
   logic [31:0] ex_pred_target_i;
   logic [31:0] alu_f_i;
   logic        alu_zero_i;
   logic [31:0] if_pc_i;
   logic        if_pred_taken_o;
   logic        redirect_o;
   logic [31:0] redirect_pc_o;
   logic [31:0] br_count_o;
   logic [31:0] mispred_count_o;

   int checks = 0;
   int errors = 0;

   branch_resolve_unit #(.BHT_ENTRIES(64), .PC_W(32)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .ex_valid_i       (ex_valid_i),
      .ex_is_branch_i   (ex_is_branch_i),
      .ex_funct3_i      (ex_funct3_i),
      .ex_pc_i          (ex_pc_i),
      .ex_imm_i         (ex_imm_i),
      .ex_pred_taken_i  (ex_pred_taken_i),
      .ex_pred_target_i (ex_pred_target_i),
      .alu_f_i          (alu_f_i),
      .alu_zero_i       (alu_zero_i),
      .if_pc_i          (if_pc_i),
      .if_pred_taken_o  (if_pred_taken_o),
      .redirect_o       (redirect_o),
      .redirect_pc_o    (redirect_pc_o),
      .br_count_o       (br_count_o),
      .mispred_count_o  (mispred_count_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic br(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                     input logic pt, input logic [31:0] ptgt, input logic [31:0] af,
                     input logic z);
      ex_valid_i       = 1'b1;
      ex_is_branch_i   = 1'b1;
      ex_funct3_i      = f3;
      ex_pc_i          = pc;
      ex_imm_i         = imm;
      ex_pred_taken_i  = pt;
      ex_pred_target_i = ptgt;
      alu_f_i          = af;
      alu_zero_i       = z;
   endtask

   task automatic idle();
      ex_valid_i     = 1'b0;
      ex_is_branch_i = 1'b0;
   endtask

   task automatic look(input string tag, input logic [31:0] pc, input logic exp);
      if_pc_i = pc;
      #1;
      chk(tag, {31'd0, if_pred_taken_o}, {31'd0, exp});
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      ex_funct3_i = 3'b000; ex_pc_i = '0; ex_imm_i = '0; ex_pred_taken_i = 1'b0;
      ex_pred_target_i = '0; alu_f_i = '0; alu_zero_i = 1'b0; if_pc_i = '0;
      #2;
      chk("rst_redirect", {31'd0, redirect_o}, 32'd0);
      chk("rst_redirect_pc", redirect_pc_o, 32'd0);
      look("rst_lookup_0", 32'h0000_0000, 1'b0);
      look("rst_lookup_3c", 32'h0000_003C, 1'b0);
      chk("rst_br_count", br_count_o, 32'd0);
      chk("rst_mispred_count", mispred_count_o, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick();

      // BEQ taken, predicted not-taken
      br(3'b000, 32'h100, 32'h40, 1'b0, 32'h0, 32'h0, 1'b1);
      look("beq_pre_update", 32'h100, 1'b0);
      tick();
      chk("beq_redirect", {31'd0, redirect_o}, 32'd1);
      chk("beq_redirect_pc", redirect_pc_o, 32'h140);
      look("beq_bht_taken", 32'h100, 1'b1);
      idle();
      tick();
      chk("beq_one_cycle", {31'd0, redirect_o}, 32'd0);
      chk("beq_pc_hold", redirect_pc_o, 32'h140);

      // BGEU not-taken, predicted correctly, twice (01->00->00)
      br(3'b111, 32'h208, 32'h8, 1'b0, 32'h0, 32'h1, 1'b0);
      tick();
      chk("bgeu1_no_redirect", {31'd0, redirect_o}, 32'd0);
      tick();
      chk("bgeu2_no_redirect", {31'd0, redirect_o}, 32'd0);
      look("bgeu_pred", 32'h208, 1'b0);
      // one taken step from saturated 00 must only reach 01
      br(3'b111, 32'h208, 32'h8, 1'b0, 32'h0, 32'h0, 1'b0);
      tick();
      chk("bgeu_taken_redirect", {31'd0, redirect_o}, 32'd1);
      chk("bgeu_taken_pc", redirect_pc_o, 32'h210);
      idle();
      look("bgeu_saturated", 32'h208, 1'b0);
      tick();

      // BNE taken, predicted taken to wrong target
      br(3'b001, 32'h300, 32'hFFFF_FE80, 1'b1, 32'h200, 32'h5, 1'b0);
      tick();
      chk("bne_tgt_redirect", {31'd0, redirect_o}, 32'd1);
      chk("bne_tgt_pc", redirect_pc_o, 32'h180);
      idle();
      tick();

      // BLT taken with correct target: no redirect
      br(3'b100, 32'h400, 32'h10, 1'b1, 32'h410, 32'h1, 1'b0);
      tick();
      chk("blt_ok_redirect", {31'd0, redirect_o}, 32'd0);
      chk("blt_ok_pc_hold", redirect_pc_o, 32'h180);

      // illegal funct3 010: ignored
      br(3'b010, 32'h404, 32'h20, 1'b1, 32'h999, 32'h0, 1'b0);
      tick();
      chk("illegal_redirect", {31'd0, redirect_o}, 32'd0);
      chk("illegal_pc_hold", redirect_pc_o, 32'h180);

      // self-squash: mispredict followed by branch in the redirect cycle
      br(3'b000, 32'h504, 32'h20, 1'b0, 32'h0, 32'h0, 1'b1);
      tick();
      chk("squash_first_redirect", {31'd0, redirect_o}, 32'd1);
      chk("squash_first_pc", redirect_pc_o, 32'h524);
      br(3'b000, 32'h50C, 32'h40, 1'b0, 32'h0, 32'h0, 1'b1);
      tick();
      idle();
      chk("squash_second_redirect", {31'd0, redirect_o}, 32'd0);
      chk("squash_pc_hold", redirect_pc_o, 32'h524);
      look("squash_bht_unchanged", 32'h50C, 1'b0);
      look("squash_first_bht", 32'h504, 1'b1);
      tick();

      // fall-through wraps to zero
      br(3'b000, 32'hFFFF_FFFC, 32'h10, 1'b1, 32'h0000_000C, 32'h0, 1'b0);
      tick();
      chk("wrap_redirect", {31'd0, redirect_o}, 32'd1);
      chk("wrap_pc", redirect_pc_o, 32'h0);
      idle();
      tick();

      // back-to-back correct branches on one index, then a not-taken one
      br(3'b110, 32'h10, 32'h8, 1'b1, 32'h18, 32'h1, 1'b0);
      tick();
      chk("b2b_1_redirect", {31'd0, redirect_o}, 32'd0);
      tick();
      chk("b2b_2_redirect", {31'd0, redirect_o}, 32'd0);
      br(3'b101, 32'h10, 32'h8, 1'b0, 32'h0, 32'h1, 1'b0);
      tick();
      idle();
      chk("b2b_3_redirect", {31'd0, redirect_o}, 32'd0);
      look("b2b_counter_11_to_10", 32'h10, 1'b1);

`ifdef BRU_STATS_EN
      chk("stats_br_mid", br_count_o, 32'd11);
      chk("stats_mis_mid", mispred_count_o, 32'd5);
`else
      chk("stats_br_off", br_count_o, 32'd0);
      chk("stats_mis_off", mispred_count_o, 32'd0);
`endif

      // reset while a redirect is pending
      br(3'b000, 32'h600, 32'h40, 1'b0, 32'h0, 32'h0, 1'b1);
      tick();
      chk("pre_reset_redirect", {31'd0, redirect_o}, 32'd1);
      idle();
      rst_n = 1'b0;
      #1;
      chk("midrst_redirect", {31'd0, redirect_o}, 32'd0);
      chk("midrst_redirect_pc", redirect_pc_o, 32'd0);
      look("midrst_lookup_100", 32'h100, 1'b0);
      look("midrst_lookup_504", 32'h504, 1'b0);
      look("midrst_lookup_10", 32'h10, 1'b0);
      chk("midrst_br_count", br_count_o, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick();

      // 3 resolves (1 mispredict) plus one illegal
      br(3'b000, 32'h700, 32'h10, 1'b1, 32'h710, 32'h0, 1'b1);
      tick();
      br(3'b001, 32'h704, 32'h10, 1'b1, 32'h714, 32'h0, 1'b0);
      tick();
      br(3'b011, 32'h708, 32'h10, 1'b0, 32'h0, 32'h1, 1'b1);
      tick();
      chk("stats_illegal_no_redirect", {31'd0, redirect_o}, 32'd0);
      br(3'b100, 32'h70C, 32'h10, 1'b0, 32'h0, 32'h1, 1'b0);
      tick();
      idle();
      chk("stats_mis_redirect", {31'd0, redirect_o}, 32'd1);
      chk("stats_mis_pc", redirect_pc_o, 32'h71C);
      tick();
`ifdef BRU_STATS_EN
      chk("stats_br_final", br_count_o, 32'd3);
      chk("stats_mis_final", mispred_count_o, 32'd1);
`else
      chk("stats_br_final_off", br_count_o, 32'd0);
      chk("stats_mis_final_off", mispred_count_o, 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
